// File: rtl/mem_bus_pkg.sv
// Shared definitions for byte-wide memory bus initiators: default widths,
// the copy engine state encoding and its per-byte cycle cost.
package mem_bus_pkg;

    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 8;
    localparam int CYCLES_PER_BYTE = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } copy_state_t;

endpackage

// File: rtl/mem_copy_master_if.sv
// Strobe and address pins of the byte-wide memory bus. The shared data
// lines are tri-state and stay a plain inout wire next to this bundle.
interface mem_copy_master_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;

    modport master (
        output mem_rd,
        output mem_wr,
        output mem_addr
    );

    modport slave (
        input mem_rd,
        input mem_wr,
        input mem_addr
    );

endinterface

// File: rtl/mem_bus_if.sv
// Bus pin stage for a byte-wide memory initiator: registers the strobes and
// address, holds the captured read byte, and drives the shared data lines
// only while the registered write strobe is high.
module mem_bus_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_nxt,
    input  logic                 wr_nxt,
    input  logic                 addr_ld,
    input  logic [ADDR_W-1:0]    addr_nxt,
    input  logic                 cap_en,
    mem_copy_master_if.master    bus,
    inout  wire  [DATA_W-1:0]    mem_data
);

    logic [DATA_W-1:0] cap_q;

    // Strobes and address are registered so the pins change only on clk edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.mem_rd   <= 1'b0;
            bus.mem_wr   <= 1'b0;
            bus.mem_addr <= '0;
        end else begin
            bus.mem_rd <= rd_nxt;
            bus.mem_wr <= wr_nxt;
            if (addr_ld) begin
                bus.mem_addr <= addr_nxt;
            end
        end
    end

    // Sample the byte the memory returns during the cycle after its read strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else if (cap_en) begin
            cap_q <= mem_data;
        end
    end

    // Drive enable is the registered write strobe itself, so the initiator can
    // never overlap the memory's read-data window.
    assign mem_data = bus.mem_wr ? cap_q : {DATA_W{1'bz}};

endmodule

// File: rtl/mem_copy_master.sv
// Byte-at-a-time memory copy engine: read source byte, capture it on the
// following cycle, write it to the destination, repeat for len bytes.
// Both pointers wrap modulo 2^ADDR_W and the copy runs strictly ascending.
module mem_copy_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    mem_copy_master_if.master    bus,
    inout  wire  [DATA_W-1:0]    mem_data
);

    copy_state_t       state, state_n;
    logic [ADDR_W-1:0] src_ptr, src_ptr_n;
    logic [ADDR_W-1:0] dst_ptr, dst_ptr_n;
    logic [LEN_W-1:0]  remaining, remaining_n;

    logic              rd_nxt;
    logic              wr_nxt;
    logic              addr_ld;
    logic [ADDR_W-1:0] addr_nxt;
    logic              cap_en;

    // State, pointers and the registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            src_ptr   <= src_ptr_n;
            dst_ptr   <= dst_ptr_n;
            remaining <= remaining_n;
            busy      <= (state_n != IDLE);
            done      <= (state_n == DONE);
        end
    end

    // Next state and next-cycle bus controls; pin values follow the next state
    // so every bus output comes straight from a register.
    always_comb begin
        state_n     = state;
        src_ptr_n   = src_ptr;
        dst_ptr_n   = dst_ptr;
        remaining_n = remaining;
        cap_en      = 1'b0;
        rd_nxt      = 1'b0;
        wr_nxt      = 1'b0;
        addr_ld     = 1'b0;
        addr_nxt    = src_ptr;

        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_n     = RD;
                        src_ptr_n   = src_addr;
                        dst_ptr_n   = dst_addr;
                        remaining_n = len;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            RD: begin
                state_n = CAP;
            end
            CAP: begin
                cap_en  = 1'b1;
                state_n = WR;
            end
            WR: begin
                src_ptr_n   = src_ptr + 1'b1;
                dst_ptr_n   = dst_ptr + 1'b1;
                remaining_n = remaining - 1'b1;
                state_n     = (remaining == LEN_W'(1)) ? DONE : RD;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        rd_nxt = (state_n == RD);
        wr_nxt = (state_n == WR);
        if (state_n == RD) begin
            addr_ld  = 1'b1;
            addr_nxt = src_ptr_n;
        end else if (state_n == WR) begin
            addr_ld  = 1'b1;
            addr_nxt = dst_ptr_n;
        end
    end

    mem_bus_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bus (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_nxt   (rd_nxt),
        .wr_nxt   (wr_nxt),
        .addr_ld  (addr_ld),
        .addr_nxt (addr_nxt),
        .cap_en   (cap_en),
        .bus      (bus),
        .mem_data (mem_data)
    );

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: byte-wide memory responder, bus monitors, and a
// reference model that applies the copy as a plain ascending array loop.
module tb_mem_copy_master;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    wire  [DW-1:0] mem_data;

    mem_copy_master_if #(.ADDR_W(AW)) bus ();

    mem_copy_master #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .LEN_W  (LW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .bus      (bus),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    // Memory responder and its preload image
    logic [7:0] mem     [256];
    logic [7:0] img     [256];
    logic [7:0] ref_mem [256];
    logic       load = 1'b0;
    logic       rd_q = 1'b0;
    logic [7:0] rd_data_q = 8'h00;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (bus.mem_wr) begin
            mem[bus.mem_addr] <= mem_data;
        end
        rd_q      <= bus.mem_rd;
        rd_data_q <= mem[bus.mem_addr];
    end

    assign mem_data = rd_q ? rd_data_q : 8'hzz;

    // Bus monitors
    logic [7:0]  rd_log [$];
    logic [15:0] wr_log [$];
    int          contention = 0;
    int          both_strobes = 0;

    always @(negedge clk) begin
        if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
        if (bus.mem_wr) wr_log.push_back({bus.mem_addr, mem_data});
        if (rd_q && bus.mem_wr) contention++;
        if (bus.mem_rd && bus.mem_wr) both_strobes++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_image();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = img[i];
    endtask

    task automatic random_image();
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    endtask

    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input int n,
                            input bit inject, input string tag);
        logic [7:0]  exp_rd [$];
        logic [15:0] exp_wr [$];
        logic [7:0]  val;
        int rd_base, wr_base, c_base, b_base;
        int busy_cnt, done_cnt, limit, mism, exp_busy;
        bit finished;

        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(8'(s + i));
            val = ref_mem[8'(s + i)];
            ref_mem[8'(d + i)] = val;
            exp_wr.push_back({8'(d + i), val});
        end

        rd_base = rd_log.size();
        wr_base = wr_log.size();
        c_base  = contention;
        b_base  = both_strobes;

        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = LW'(n);
        @(negedge clk);
        start    = 1'b0;

        busy_cnt = 0;
        done_cnt = 0;
        finished = 1'b0;
        limit    = 3 * n + 10;
        for (int cyc = 0; cyc < limit; cyc++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (inject && cyc == 2) begin
                src_addr = s + 8'h33;
                dst_addr = d + 8'h55;
                len      = LW'(3);
            end
            start = inject && (cyc == 2);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);

        exp_busy = (n == 0) ? 1 : 3 * n + 1;
        check({tag, " finished"}, 32'(finished), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " rd_count"}, 32'(rd_log.size() - rd_base), 32'(n));
        check({tag, " wr_count"}, 32'(wr_log.size() - wr_base), 32'(n));
        for (int i = 0; i < n && (rd_base + i) < rd_log.size(); i++)
            check({tag, " rd_addr"}, 32'(rd_log[rd_base + i]), 32'(exp_rd[i]));
        for (int i = 0; i < n && (wr_base + i) < wr_log.size(); i++)
            check({tag, " wr_addr_data"}, 32'(wr_log[wr_base + i]), 32'(exp_wr[i]));
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check({tag, " mem_mismatches"}, 32'(mism), 32'd0);
        check({tag, " contention"}, 32'(contention - c_base), 32'd0);
        check({tag, " rd_wr_overlap"}, 32'(both_strobes - b_base), 32'd0);
        check({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int rd_base, wr_base, n;
        logic [7:0] s, d;

        rst_n    = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset mem_rd", 32'(bus.mem_rd), 32'd0);
        check("reset mem_wr", 32'(bus.mem_wr), 32'd0);
        check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset busy", 32'(busy), 32'd0);

        // Four-byte copy
        random_image();
        img[8'h10] = 8'hA1; img[8'h11] = 8'hB2; img[8'h12] = 8'hC3; img[8'h13] = 8'hD4;
        load_image();
        run_copy(8'h10, 8'h40, 4, 1'b0, "copy4");
        check("copy4 byte0", 32'(mem[8'h40]), 32'hA1);
        check("copy4 byte3", 32'(mem[8'h43]), 32'hD4);

        // Zero length
        random_image();
        load_image();
        run_copy(8'h00, 8'h80, 0, 1'b0, "len0");

        // Address wrap on the source side
        random_image();
        img[8'hFE] = 8'h11; img[8'hFF] = 8'h22; img[8'h00] = 8'h33;
        load_image();
        run_copy(8'hFE, 8'h01, 3, 1'b0, "wrap");
        check("wrap byte2", 32'(mem[8'h03]), 32'h33);

        // Overlapping ascending copy propagates the first byte
        random_image();
        img[8'h20] = 8'h5A;
        load_image();
        run_copy(8'h20, 8'h21, 3, 1'b0, "overlap");
        check("overlap last", 32'(mem[8'h23]), 32'h5A);

        // Start while busy is ignored
        random_image();
        load_image();
        run_copy(8'h30, 8'h90, 2, 1'b1, "busy_start");

        // Reset during the write of byte 2
        random_image();
        load_image();
        s = 8'h50;
        d = 8'h60;
        rd_base = rd_log.size();
        wr_base = wr_log.size();
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = LW'(4);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("rstmid in_wr2", 32'(bus.mem_wr), 32'd1);
        check("rstmid wr2_addr", 32'(bus.mem_addr), 32'(8'(d + 1)));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid done", 32'(done), 32'd0);
        check("rstmid mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rstmid mem_rd", 32'(bus.mem_rd), 32'd0);
        repeat (6) @(negedge clk);
        check("rstmid byte1", 32'(mem[d]), 32'(img[s]));
        check("rstmid byte3", 32'(mem[8'(d + 2)]), 32'(img[8'(d + 2)]));
        check("rstmid byte4", 32'(mem[8'(d + 3)]), 32'(img[8'(d + 3)]));
        check("rstmid writes", 32'(wr_log.size() - wr_base), 32'd2);
        check("rstmid reads", 32'(rd_log.size() - rd_base), 32'd2);
        check("rstmid stays idle", 32'(busy), 32'd0);

        // Randomized copies
        for (int t = 0; t < 8; t++) begin
            random_image();
            load_image();
            n = $urandom_range(0, 24);
            run_copy(8'($urandom), 8'($urandom), n, 1'b0, "random");
        end

        // Full address-space copy
        random_image();
        load_image();
        run_copy(8'($urandom), 8'($urandom), 256, 1'b0, "full256");

        check("total contention", 32'(contention), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
